control_unit: RTL and testbench
===============================

# control_unit

Multi-cycle controller that drives the 64-bit LEGv8-subset datapath. It fetches a 32-bit instruction from ROM and latches it into an instruction register (IR). It then decodes the IR and sequences the datapath's full control word (register addresses, constant, ALU select, bus enables, memory and PC controls) over 2–3 cycles per instruction. The datapath's 5-bit status output is its only feedback input.

## Interface
Parameters:
- XZR, 31, register index that reads as zero; used as the B operand for CBZ/CBNZ tests.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr  in  32  ROM data at rom_addr; valid during FETCH.
- status  in  5  {v, c, n, z, z_imm}:
  - v, c, n, z: stored flags.
  - z_imm: combinational zero flag of the current ALU result.
- k  out  64  constant to the B mux and the PC mux.
- reg_addr, a_addr, b_addr  out  5 each  register-file write, A-read and B-read addresses.
- fs  out  5  ALU function select.
- ps  out  2  PC select: 00 hold, 01 +4, 10 load, 11 add offset.
- reg_w, b_sel, b_en, alu_en, mem_en, chip_sel, mem_w, mem_r, stat_en, pc_reg_en, pc_rom_en, pc_sel, c0  out  1 each  datapath controls.
- halted  out  1  high once HLT has executed.

## Operation
- State register values: FETCH, EXEC, MEM2, HALT. Control outputs are a combinational function of state, IR and status.
- Default for every control bit is 0 and every address 0. Exceptions:
  - b_addr defaults to XZR.
  - At most one d-bus driver (b_en, alu_en, chip_sel, pc_reg_en) is high in any state.
- FETCH: pc_rom_en=1, ps=00; IR<=instr; next state EXEC.
- EXEC, by IR class:
  - R-type ADD/SUB/AND/ORR/EOR/ADDS/SUBS: a_addr=Rn, b_addr=Rm, b_sel=0, alu_en=1, reg_w=1, reg_addr=Rd, ps=01. SUB/SUBS also set c0=1. ADDS/SUBS also set stat_en=1. Next state FETCH.
  - ADDI/SUBI: as R-type but b_sel=1, k=zero-extended imm12.
  - LDUR/STUR: a_addr=Rn, b_sel=1, k=sign-extended imm9, fs=ADD, alu_en=1, mem_en=1, ps=00. The RAM captures the address at this edge. Next state MEM2.
  - B: pc_sel=1, k=sext(imm26)<<2, ps=11. Next state FETCH.
  - CBZ/CBNZ: a_addr=Rt, b_addr=XZR, fs=ADD, pc_sel=1, k=sext(imm19)<<2. Branch is taken when z_imm=1 for CBZ, or z_imm=0 for CBNZ. ps=11 if taken, else 01.
  - B.cond: evaluates the stored flags; k and pc_sel as for CBZ.
    - Supported codes: EQ, NE, HS, LO, MI, PL, VS, VC, GE, LT, GT, LE, AL.
    - Codes 8, 9 and 15 are never taken.
  - HLT (0xD4400000): ps=00; next state HALT.
  - Any other encoding: NOP, ps=01.
- MEM2:
  - LDUR: mem_r=1, chip_sel=1, reg_w=1, reg_addr=Rt, ps=01.
  - STUR: b_addr=Rt, b_en=1, mem_w=1, ps=01.
  - Next state FETCH.
- HALT: all controls 0, halted=1; stays in HALT until rst.
- Writes with Rd=XZR are still issued; the register file ignores them.

## Timing
- Reset (asynchronous): state=FETCH, IR=0, halted=0. While rst is high, all write and enable outputs are 0 except pc_rom_en=1.
- Instruction latency: FETCH+EXEC is 2 cycles for ALU, branch and NOP instructions; LDUR/STUR take 3 cycles.
- The PC changes only on the last cycle of an instruction.
- rst asserted mid-instruction aborts it; no partial memory write occurs after the rst edge.
- Status is sampled combinationally in EXEC. stat_en from an ADDS/SUBS takes effect at that instruction's EXEC edge, so an immediately following B.cond sees the updated flags.

## Structure
- Shared include/package cpu_defs holds:
  - opcode constants (11/10/8/6-bit fields);
  - FS_AND=00000, FS_OR=00100, FS_ADD=01000, FS_SUB=01001, FS_XOR=01100;
  - PS_HOLD/PS_INC/PS_LOAD/PS_OFF;
  - state encodings;
  - condition codes.
- Sub-module instr_decode: a combinational IR-to-class/field extractor (class, Rd, Rn, Rm/Rt, immediates sign-extended to 64 bits).

## Test plan
- Reset then ADDI X1,XZR,#5: EXEC drives k=5, b_sel=1, alu_en=1, reg_w=1, reg_addr=1, ps=01; the next FETCH has pc_rom_en=1.
- SUBS X2,X1,X1, then B.EQ #+3: stat_en=1 in the SUBS EXEC. With status z=1 the B.EQ yields ps=11, k=12; with z=0 it yields ps=01.
- LDUR X3,[X1,#-8]: EXEC k=0xFFFF_FFFF_FFFF_FFF8, mem_en=1, ps=00; MEM2 chip_sel=1, reg_w=1, reg_addr=3, ps=01.
- STUR X3,[X1,#0]: MEM2 b_addr=3, b_en=1, mem_w=1. Check on every cycle that no two d-bus drivers are high.
- CBNZ X4,#-2 with z_imm=0: taken, ps=11, k=0xFFFF_FFFF_FFFF_FFF8. With z_imm=1: ps=01.
- HLT, then rst pulse mid-EXEC of a following program: halted=1 and all controls 0 until rst; on rst, state returns to FETCH asynchronously.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared LEGv8-subset definitions: opcodes, ALU/PC selects, FSM states,
// condition codes, decoded-instruction record and the flag evaluator.
package cpu_defs;

  // 11-bit R/D-format opcodes (IR[31:21])
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_EOR  = 11'h650;
  localparam logic [10:0] OP_ADDS = 11'h558;
  localparam logic [10:0] OP_SUBS = 11'h758;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;

  // 10-bit I-format opcodes (IR[31:22])
  localparam logic [9:0] OP_ADDI = 10'h244;
  localparam logic [9:0] OP_SUBI = 10'h344;

  // 8-bit CB-format opcodes (IR[31:24])
  localparam logic [7:0] OP_CBZ   = 8'hB4;
  localparam logic [7:0] OP_CBNZ  = 8'hB5;
  localparam logic [7:0] OP_BCOND = 8'h54;

  // 6-bit B-format opcode (IR[31:26])
  localparam logic [5:0] OP_B = 6'h05;

  localparam logic [31:0] INSTR_HLT = 32'hD440_0000;

  // ALU function selects
  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_OR  = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] FS_XOR = 5'b01100;

  // PC selects
  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_LOAD = 2'b10;
  localparam logic [1:0] PS_OFF  = 2'b11;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM2  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    CC_EQ = 4'd0,  CC_NE = 4'd1,  CC_HS = 4'd2,  CC_LO = 4'd3,
    CC_MI = 4'd4,  CC_PL = 4'd5,  CC_VS = 4'd6,  CC_VC = 4'd7,
    CC_HI = 4'd8,  CC_LS = 4'd9,  CC_GE = 4'd10, CC_LT = 4'd11,
    CC_GT = 4'd12, CC_LE = 4'd13, CC_AL = 4'd14, CC_NV = 4'd15
  } cond_t;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_ALU_R, CLS_ALU_I, CLS_LDUR, CLS_STUR,
    CLS_B, CLS_CBZ, CLS_CBNZ, CLS_BCOND, CLS_HLT
  } instr_class_t;

  typedef struct packed {
    instr_class_t cls;
    logic [4:0]   fs;         // ALU op for ALU classes
    logic         c0;         // carry-in for subtraction
    logic         set_flags;  // ADDS/SUBS
    logic [4:0]   rd;
    logic [4:0]   rn;
    logic [4:0]   rm;
    logic [4:0]   rt;
    cond_t        cond;
    logic [63:0]  imm12;      // zero-extended
    logic [63:0]  imm9;       // sign-extended
    logic [63:0]  br26;       // sign-extended, word offset in bytes
    logic [63:0]  br19;       // sign-extended, word offset in bytes
  } decoded_t;

  // HI/LS and NV are deliberately unsupported and never taken.
  function automatic logic cond_met(input cond_t cc, input logic v, input logic c,
                                    input logic n, input logic z);
    logic taken;
    case (cc)
      CC_EQ:   taken = z;
      CC_NE:   taken = !z;
      CC_HS:   taken = c;
      CC_LO:   taken = !c;
      CC_MI:   taken = n;
      CC_PL:   taken = !n;
      CC_VS:   taken = v;
      CC_VC:   taken = !v;
      CC_GE:   taken = (n == v);
      CC_LT:   taken = (n != v);
      CC_GT:   taken = !z && (n == v);
      CC_LE:   taken = z || (n != v);
      CC_AL:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/control_unit_instr_decode.sv
// Combinational IR decoder: instruction class, register fields and
// 64-bit extended immediates.
module instr_decode
  import cpu_defs::*;
(
  input  logic [31:0] ir,
  output decoded_t    dec
);

  // Classify the IR and extract every field regardless of class.
  always_comb begin
    // NOTE: assign every output a default first so no path leaves a value held (no latch).
    dec           = '0;
    dec.cls       = CLS_NOP;
    dec.rd        = ir[4:0];
    dec.rt        = ir[4:0];
    dec.rn        = ir[9:5];
    dec.rm        = ir[20:16];
    dec.cond      = cond_t'(ir[3:0]);
    dec.imm12     = {52'd0, ir[21:10]};
    dec.imm9      = {{55{ir[20]}}, ir[20:12]};
    dec.br26      = {{36{ir[25]}}, ir[25:0], 2'b00};
    dec.br19      = {{43{ir[23]}}, ir[23:5], 2'b00};

    if (ir == INSTR_HLT) begin
      dec.cls = CLS_HLT;
    end else begin
      case (ir[31:21])
        OP_ADD:  begin dec.cls = CLS_ALU_R; dec.fs = FS_ADD; end
        OP_ADDS: begin dec.cls = CLS_ALU_R; dec.fs = FS_ADD; dec.set_flags = 1'b1; end
        OP_SUB:  begin dec.cls = CLS_ALU_R; dec.fs = FS_SUB; dec.c0 = 1'b1; end
        OP_SUBS: begin dec.cls = CLS_ALU_R; dec.fs = FS_SUB; dec.c0 = 1'b1; dec.set_flags = 1'b1; end
        OP_AND:  begin dec.cls = CLS_ALU_R; dec.fs = FS_AND; end
        OP_ORR:  begin dec.cls = CLS_ALU_R; dec.fs = FS_OR;  end
        OP_EOR:  begin dec.cls = CLS_ALU_R; dec.fs = FS_XOR; end
        OP_LDUR: dec.cls = CLS_LDUR;
        OP_STUR: dec.cls = CLS_STUR;
        default: begin
          if (ir[31:22] == OP_ADDI) begin
            dec.cls = CLS_ALU_I;
            dec.fs  = FS_ADD;
          end else if (ir[31:22] == OP_SUBI) begin
            dec.cls = CLS_ALU_I;
            dec.fs  = FS_SUB;
            dec.c0  = 1'b1;
          end else if (ir[31:24] == OP_CBZ) begin
            dec.cls = CLS_CBZ;
          end else if (ir[31:24] == OP_CBNZ) begin
            dec.cls = CLS_CBNZ;
          end else if (ir[31:24] == OP_BCOND) begin
            dec.cls = CLS_BCOND;
          end else if (ir[31:26] == OP_B) begin
            dec.cls = CLS_B;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle LEGv8-subset controller: FETCH latches the IR, EXEC drives the
// datapath control word, MEM2 finishes loads/stores, HALT parks after HLT.
module control_unit
  import cpu_defs::*;
#(
  parameter logic [4:0] XZR = 5'd31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [4:0]  status,
  output logic [63:0] k,
  output logic [4:0]  reg_addr,
  output logic [4:0]  a_addr,
  output logic [4:0]  b_addr,
  output logic [4:0]  fs,
  output logic [1:0]  ps,
  output logic        reg_w,
  output logic        b_sel,
  output logic        b_en,
  output logic        alu_en,
  output logic        mem_en,
  output logic        chip_sel,
  output logic        mem_w,
  output logic        mem_r,
  output logic        stat_en,
  output logic        pc_reg_en,
  output logic        pc_rom_en,
  output logic        pc_sel,
  output logic        c0,
  output logic        halted
);

  state_t     state, state_next;
  logic [31:0] ir;
  decoded_t   dec;
  logic       flag_v, flag_c, flag_n, flag_z, z_imm;

  assign {flag_v, flag_c, flag_n, flag_z, z_imm} = status;

  instr_decode u_decode (
    .ir  (ir),
    .dec (dec)
  );

  // State register and instruction register; IR loads only in FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_FETCH;
      ir    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      if (state == ST_FETCH) ir <= instr;
    end
  end

  // Next-state and control-word generation from state, IR and status.
  always_comb begin
    state_next = state;
    k          = '0;
    reg_addr   = '0;
    a_addr     = '0;
    b_addr     = XZR;
    fs         = '0;
    ps         = PS_HOLD;
    reg_w      = 1'b0;
    b_sel      = 1'b0;
    b_en       = 1'b0;
    alu_en     = 1'b0;
    mem_en     = 1'b0;
    chip_sel   = 1'b0;
    mem_w      = 1'b0;
    mem_r      = 1'b0;
    stat_en    = 1'b0;
    pc_reg_en  = 1'b0;
    pc_rom_en  = 1'b0;
    pc_sel     = 1'b0;
    c0         = 1'b0;
    halted     = 1'b0;

    case (state)
      ST_FETCH: begin
        pc_rom_en  = 1'b1;
        ps         = PS_HOLD;
        state_next = ST_EXEC;
      end

      ST_EXEC: begin
        state_next = ST_FETCH;
        case (dec.cls)
          CLS_ALU_R, CLS_ALU_I: begin
            a_addr   = dec.rn;
            b_addr   = (dec.cls == CLS_ALU_R) ? dec.rm : XZR;
            b_sel    = (dec.cls == CLS_ALU_I);
            k        = (dec.cls == CLS_ALU_I) ? dec.imm12 : '0;
            fs       = dec.fs;
            c0       = dec.c0;
            stat_en  = dec.set_flags;
            alu_en   = 1'b1;
            reg_w    = 1'b1;
            reg_addr = dec.rd;
            ps       = PS_INC;
          end
          CLS_LDUR, CLS_STUR: begin
            // Address goes out through the ALU; the RAM captures it at this edge.
            a_addr     = dec.rn;
            b_sel      = 1'b1;
            k          = dec.imm9;
            fs         = FS_ADD;
            alu_en     = 1'b1;
            mem_en     = 1'b1;
            ps         = PS_HOLD;
            state_next = ST_MEM2;
          end
          CLS_B: begin
            pc_sel = 1'b1;
            k      = dec.br26;
            ps     = PS_OFF;
          end
          CLS_CBZ, CLS_CBNZ: begin
            // Rt + XZR through the ALU exposes Rt==0 on z_imm.
            a_addr = dec.rt;
            b_addr = XZR;
            fs     = FS_ADD;
            pc_sel = 1'b1;
            k      = dec.br19;
            ps     = ((dec.cls == CLS_CBZ) == z_imm) ? PS_OFF : PS_INC;
          end
          CLS_BCOND: begin
            pc_sel = 1'b1;
            k      = dec.br19;
            ps     = cond_met(dec.cond, flag_v, flag_c, flag_n, flag_z) ? PS_OFF : PS_INC;
          end
          CLS_HLT: begin
            ps         = PS_HOLD;
            state_next = ST_HALT;
          end
          default: ps = PS_INC;
        endcase
      end

      ST_MEM2: begin
        state_next = ST_FETCH;
        ps         = PS_INC;
        if (dec.cls == CLS_LDUR) begin
          mem_r    = 1'b1;
          chip_sel = 1'b1;
          reg_w    = 1'b1;
          reg_addr = dec.rt;
        end else begin
          b_addr = dec.rt;
          b_en   = 1'b1;
          mem_w  = 1'b1;
        end
      end

      ST_HALT: begin
        halted     = 1'b1;
        state_next = ST_HALT;
      end

      default: state_next = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed table-driven bench for control_unit plus hand-written sequences
// for HLT, asynchronous reset mid-instruction and d-bus exclusivity.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [4:0]  status;
  logic [63:0] k;
  logic [4:0]  reg_addr, a_addr, b_addr, fs;
  logic [1:0]  ps;
  logic reg_w, b_sel, b_en, alu_en, mem_en, chip_sel, mem_w, mem_r;
  logic stat_en, pc_reg_en, pc_rom_en, pc_sel, c0, halted;

  int checks = 0;
  int errors = 0;

  control_unit #(.XZR(5'd31)) dut (
    .clk(clk), .rst(rst), .instr(instr), .status(status),
    .k(k), .reg_addr(reg_addr), .a_addr(a_addr), .b_addr(b_addr), .fs(fs), .ps(ps),
    .reg_w(reg_w), .b_sel(b_sel), .b_en(b_en), .alu_en(alu_en), .mem_en(mem_en),
    .chip_sel(chip_sel), .mem_w(mem_w), .mem_r(mem_r), .stat_en(stat_en),
    .pc_reg_en(pc_reg_en), .pc_rom_en(pc_rom_en), .pc_sel(pc_sel), .c0(c0),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] k;
    logic [4:0]  reg_addr;
    logic [4:0]  a_addr;
    logic [4:0]  b_addr;
    logic [4:0]  fs;
    logic [1:0]  ps;
    logic [12:0] bits;
    logic        halted;
  } cw_t;

  localparam logic [12:0] M_REGW  = 13'h1000;
  localparam logic [12:0] M_BSEL  = 13'h0800;
  localparam logic [12:0] M_BEN   = 13'h0400;
  localparam logic [12:0] M_ALUEN = 13'h0200;
  localparam logic [12:0] M_MEMEN = 13'h0100;
  localparam logic [12:0] M_CS    = 13'h0080;
  localparam logic [12:0] M_MEMW  = 13'h0040;
  localparam logic [12:0] M_MEMR  = 13'h0020;
  localparam logic [12:0] M_STAT  = 13'h0010;
  localparam logic [12:0] M_PCREG = 13'h0008;
  localparam logic [12:0] M_PCROM = 13'h0004;
  localparam logic [12:0] M_PCSEL = 13'h0002;
  localparam logic [12:0] M_C0    = 13'h0001;

  localparam logic [4:0] F_AND = 5'b00000, F_OR = 5'b00100, F_ADD = 5'b01000,
                         F_SUB = 5'b01001, F_XOR = 5'b01100;

  function automatic cw_t cw(input logic [63:0] kk, input logic [4:0] ra, input logic [4:0] aa,
                             input logic [4:0] ba, input logic [4:0] f, input logic [1:0] p,
                             input logic [12:0] b, input logic h);
    cw_t r;
    r.k = kk; r.reg_addr = ra; r.a_addr = aa; r.b_addr = ba;
    r.fs = f; r.ps = p; r.bits = b; r.halted = h;
    return r;
  endfunction

  function automatic cw_t sample();
    cw_t r;
    r.k = k; r.reg_addr = reg_addr; r.a_addr = a_addr; r.b_addr = b_addr;
    r.fs = fs; r.ps = ps;
    r.bits = {reg_w, b_sel, b_en, alu_en, mem_en, chip_sel, mem_w, mem_r,
              stat_en, pc_reg_en, pc_rom_en, pc_sel, c0};
    r.halted = halted;
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // At most one d-bus driver in any cycle.
  always @(negedge clk) begin
    check("dbus_exclusive",
          128'($countones({b_en, alu_en, chip_sel, pc_reg_en}) > 1), 128'(0));
  end

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [4:0]  status;
    cw_t         exec_exp;
    logic        has_mem2;
    cw_t         mem2_exp;
  } vec_t;

  vec_t vecs[$];
  cw_t  fetch_cw;
  cw_t  idle_cw;

  task automatic add(input string n, input logic [31:0] ins, input logic [4:0] st,
                     input cw_t e, input logic m, input cw_t m2);
    vec_t v;
    v.name = n; v.instr = ins; v.status = st; v.exec_exp = e; v.has_mem2 = m; v.mem2_exp = m2;
    vecs.push_back(v);
  endtask

  // Entered at a negedge while in FETCH; leaves at a negedge in the next FETCH.
  task automatic run_vec(input vec_t v);
    instr  = v.instr;
    status = v.status;
    #1;
    check({v.name, "_fetch"}, 128'(sample()), 128'(fetch_cw));
    @(negedge clk);
    check({v.name, "_exec"}, 128'(sample()), 128'(v.exec_exp));
    if (v.has_mem2) begin
      @(negedge clk);
      check({v.name, "_mem2"}, 128'(sample()), 128'(v.mem2_exp));
    end
    @(negedge clk);
  endtask

  initial begin
    rst    = 1'b1;
    instr  = '0;
    status = '0;
    fetch_cw = cw(64'd0, 5'd0, 5'd0, 5'd31, 5'd0, 2'b00, M_PCROM, 1'b0);
    idle_cw  = cw(64'd0, 5'd0, 5'd0, 5'd31, 5'd0, 2'b00, 13'd0, 1'b0);

    add("addi",    32'h910017E1, 5'b00000, cw(64'd5, 5'd1, 5'd31, 5'd31, F_ADD, 2'b01, M_REGW | M_BSEL | M_ALUEN, 1'b0), 1'b0, idle_cw);
    add("subs",    32'hEB010022, 5'b00000, cw(64'd0, 5'd2, 5'd1, 5'd1, F_SUB, 2'b01, M_REGW | M_ALUEN | M_C0 | M_STAT, 1'b0), 1'b0, idle_cw);
    add("beq_t",   32'h54000060, 5'b00010, cw(64'd12, 5'd0, 5'd0, 5'd31, 5'd0, 2'b11, M_PCSEL, 1'b0), 1'b0, idle_cw);
    add("beq_nt",  32'h54000060, 5'b00000, cw(64'd12, 5'd0, 5'd0, 5'd31, 5'd0, 2'b01, M_PCSEL, 1'b0), 1'b0, idle_cw);
    add("ldur",    32'hF85F8023, 5'b00000, cw(64'hFFFF_FFFF_FFFF_FFF8, 5'd0, 5'd1, 5'd31, F_ADD, 2'b00, M_BSEL | M_ALUEN | M_MEMEN, 1'b0),
                                  1'b1,    cw(64'd0, 5'd3, 5'd0, 5'd31, 5'd0, 2'b01, M_CS | M_MEMR | M_REGW, 1'b0));
    add("stur",    32'hF8000023, 5'b00000, cw(64'd0, 5'd0, 5'd1, 5'd31, F_ADD, 2'b00, M_BSEL | M_ALUEN | M_MEMEN, 1'b0),
                                  1'b1,    cw(64'd0, 5'd0, 5'd0, 5'd3, 5'd0, 2'b01, M_BEN | M_MEMW, 1'b0));
    add("cbnz_t",  32'hB5FFFFC4, 5'b00000, cw(64'hFFFF_FFFF_FFFF_FFF8, 5'd0, 5'd4, 5'd31, F_ADD, 2'b11, M_PCSEL, 1'b0), 1'b0, idle_cw);
    add("cbnz_nt", 32'hB5FFFFC4, 5'b00001, cw(64'hFFFF_FFFF_FFFF_FFF8, 5'd0, 5'd4, 5'd31, F_ADD, 2'b01, M_PCSEL, 1'b0), 1'b0, idle_cw);
    add("cbz_t",   32'hB4000024, 5'b00001, cw(64'd4, 5'd0, 5'd4, 5'd31, F_ADD, 2'b11, M_PCSEL, 1'b0), 1'b0, idle_cw);
    add("add",     32'h8B0700C5, 5'b00000, cw(64'd0, 5'd5, 5'd6, 5'd7, F_ADD, 2'b01, M_REGW | M_ALUEN, 1'b0), 1'b0, idle_cw);
    add("and",     32'h8A030041, 5'b00000, cw(64'd0, 5'd1, 5'd2, 5'd3, F_AND, 2'b01, M_REGW | M_ALUEN, 1'b0), 1'b0, idle_cw);
    add("orr",     32'hAA0E01AC, 5'b00000, cw(64'd0, 5'd12, 5'd13, 5'd14, F_OR, 2'b01, M_REGW | M_ALUEN, 1'b0), 1'b0, idle_cw);
    add("eor",     32'hCA0B0149, 5'b00000, cw(64'd0, 5'd9, 5'd10, 5'd11, F_XOR, 2'b01, M_REGW | M_ALUEN, 1'b0), 1'b0, idle_cw);
    add("subi",    32'hD13FFC42, 5'b00000, cw(64'hFFF, 5'd2, 5'd2, 5'd31, F_SUB, 2'b01, M_REGW | M_BSEL | M_ALUEN | M_C0, 1'b0), 1'b0, idle_cw);
    add("b_neg",   32'h17FFFFFF, 5'b00000, cw(64'hFFFF_FFFF_FFFF_FFFC, 5'd0, 5'd0, 5'd31, 5'd0, 2'b11, M_PCSEL, 1'b0), 1'b0, idle_cw);
    add("bhi_nv",  32'h54000028, 5'b01000, cw(64'd4, 5'd0, 5'd0, 5'd31, 5'd0, 2'b01, M_PCSEL, 1'b0), 1'b0, idle_cw);
    add("bgt_t",   32'h5400002C, 5'b00000, cw(64'd4, 5'd0, 5'd0, 5'd31, 5'd0, 2'b11, M_PCSEL, 1'b0), 1'b0, idle_cw);
    add("blt_t",   32'h5400002B, 5'b00100, cw(64'd4, 5'd0, 5'd0, 5'd31, 5'd0, 2'b11, M_PCSEL, 1'b0), 1'b0, idle_cw);
    add("bge_nt",  32'h5400002A, 5'b00100, cw(64'd4, 5'd0, 5'd0, 5'd31, 5'd0, 2'b01, M_PCSEL, 1'b0), 1'b0, idle_cw);
    add("bal_t",   32'h5400002E, 5'b00000, cw(64'd4, 5'd0, 5'd0, 5'd31, 5'd0, 2'b11, M_PCSEL, 1'b0), 1'b0, idle_cw);
    add("nop",     32'h00000000, 5'b00000, cw(64'd0, 5'd0, 5'd0, 5'd31, 5'd0, 2'b01, 13'd0, 1'b0), 1'b0, idle_cw);

    // Outputs held in FETCH form while reset is asserted.
    #12;
    check("reset_hold", 128'(sample()), 128'(fetch_cw));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // HLT: EXEC holds the PC, then HALT parks until reset.
    instr = 32'hD440_0000;
    status = 5'b00000;
    #1;
    check("hlt_fetch", 128'(sample()), 128'(fetch_cw));
    @(negedge clk);
    check("hlt_exec", 128'(sample()), 128'(idle_cw));
    instr = 32'h910017E1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halt_stay", 128'(sample()), 128'(cw(64'd0, 5'd0, 5'd0, 5'd31, 5'd0, 2'b00, 13'd0, 1'b1)));
    end
    #1 rst = 1'b1;
    #1;
    check("halt_async_rst", 128'(sample()), 128'(fetch_cw));
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of an ADDI EXEC aborts it without a clock edge.
    #1;
    check("abort_fetch", 128'(sample()), 128'(fetch_cw));
    @(negedge clk);
    check("abort_exec", 128'(sample()), 128'(vecs[0].exec_exp));
    #2 rst = 1'b1;
    #1;
    check("rst_mid_exec", 128'(sample()), 128'(fetch_cw));
    @(negedge clk);
    check("rst_held", 128'(sample()), 128'(fetch_cw));
    rst = 1'b0;

    // Reset during STUR MEM2 drops mem_w immediately.
    instr = 32'hF8000023;
    #1;
    @(negedge clk);
    @(negedge clk);
    check("stur_mem2_pre", 128'(sample()), 128'(vecs[5].mem2_exp));
    #1 rst = 1'b1;
    #1;
    check("rst_mid_mem2", 128'(sample()), 128'(fetch_cw));
    @(negedge clk);
    rst = 1'b0;

    // Clean restart after the aborted store.
    run_vec(vecs[0]);
    run_vec(vecs[5]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
